// File: rtl/link_pkg.sv
// Shared definitions for the serial link receive buffer: default word width,
// deserializer state encoding and drop-counter width.
package link_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DROP_W     = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/link_rx_buf_if.sv
// Consumer-side word handshake of the link receive buffer.
// Signal names follow the buffer's point of view (o_ = driven by the buffer).
interface link_rx_buf_if #(
  parameter int DATA_W = link_pkg::DATA_W_DEF
);

  logic [DATA_W-1:0] o_data;
  logic              o_vld;
  logic              i_rdy;

  modport master (
    output o_data,
    output o_vld,
    input  i_rdy
  );

  modport slave (
    input  o_data,
    input  o_vld,
    output i_rdy
  );

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; head word is presented combinationally
// and forced to zero while empty. Storage is not reset.
module sync_fifo #(
  parameter  int DATA_W     = 16,
  parameter  int FIFO_DEPTH = 8,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int LVL_W      = PTR_W + 1
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [LVL_W-1:0]  o_level
);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [LVL_W-1:0]  r_level;
  logic              w_pop;
  logic              w_push;

  assign o_full  = (r_level == LVL_W'(FIFO_DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

  // A pop frees a slot in the same cycle, so a push while full is accepted then.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  assign o_data = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_push_data;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/link_rx_buf.sv
// Serial link receiver: deserializes MSB-first frames marked by i_fs and queues
// complete words in a FWFT buffer with sticky overflow/frame-error flags.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for a frame strobe
//   ST_SHIFT | collecting bits; r_cnt counts remaining bits down to 0
module link_rx_buf
  import link_pkg::*;
#(
  parameter  int DATA_W     = DATA_W_DEF,
  parameter  int FIFO_DEPTH = 8,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               i_fs,
  input  logic               i_d,
  link_rx_buf_if.master      rx,
  input  logic               i_clr,
  output logic               o_ovf,
  output logic               o_ferr,
  output logic [DROP_W-1:0]  o_drop_cnt,
  output logic [LVL_W-1:0]   o_level
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(DATA_W - 2);

  rx_state_t         r_state;
  rx_state_t         w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_push;
  logic              w_start;
  logic              w_shift;
  logic              w_done;
  logic              w_ferr_set;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_drop;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_fs) begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (i_fs) begin
          w_state_nxt = ST_SHIFT;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A strobe inside a frame (including on the expected LSB cycle) restarts.
  always_comb begin
    w_start    = 1'b0;
    w_shift    = 1'b0;
    w_done     = 1'b0;
    w_ferr_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_start = i_fs;
      end
      ST_SHIFT: begin
        if (i_fs) begin
          w_start    = 1'b1;
          w_ferr_set = 1'b1;
        end else begin
          w_shift = 1'b1;
          w_done  = (r_cnt == '0);
        end
      end
      default: ;
    endcase
  end

  // r_shift still holds the finished word on the push cycle, even if a new
  // frame loads it on that same edge.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_push  <= 1'b0;
    end else begin
      r_push <= w_done;
      if (w_start) begin
        r_shift <= {{(DATA_W-1){1'b0}}, i_d};
        r_cnt   <= CNT_INIT;
      end else if (w_shift) begin
        r_shift <= {r_shift[DATA_W-2:0], i_d};
        if (!w_done) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end
  end

  assign rx.o_vld = ~w_empty;
  assign w_pop    = rx.o_vld & rx.i_rdy;
  assign w_drop   = r_push & w_full & ~w_pop;

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .i_push      (r_push),
    .i_push_data (r_shift),
    .i_pop       (w_pop),
    .o_data      (rx.o_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (o_level)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ovf      <= 1'b0;
      o_ferr     <= 1'b0;
      o_drop_cnt <= '0;
    end else if (i_clr) begin
      o_ovf      <= 1'b0;
      o_ferr     <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      if (w_drop) begin
        o_ovf <= 1'b1;
        if (o_drop_cnt != '1) begin
          o_drop_cnt <= o_drop_cnt + DROP_W'(1);
        end
      end
      if (w_ferr_set) begin
        o_ferr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_link_rx_buf.sv
// Scoreboard bench for link_rx_buf: frames push expected words into a queue,
// a negedge monitor pops and compares every transferred word.
`timescale 1ns/1ps
module tb_link_rx_buf;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        i_fs;
  logic        i_d;
  logic        i_clr;
  logic        o_ovf;
  logic        o_ferr;
  logic [7:0]  o_drop_cnt;
  logic [3:0]  o_level;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  time         t_fs = 0;
  bit          lat_rec = 0;
  bit          lat_arm = 0;
  bit          hold_prev = 0;
  logic [15:0] prev_data = '0;

  link_rx_buf_if #(.DATA_W(16)) rx_if ();

  link_rx_buf #(.DATA_W(16), .FIFO_DEPTH(8)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .i_fs       (i_fs),
    .i_d        (i_d),
    .rx         (rx_if),
    .i_clr      (i_clr),
    .o_ovf      (o_ovf),
    .o_ferr     (o_ferr),
    .o_drop_cnt (o_drop_cnt),
    .o_level    (o_level)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_bit(input logic fs, input logic d);
    @(posedge sys_clk);
    #1;
    i_fs = fs;
    i_d  = d;
  endtask

  task automatic send_frame(input logic [15:0] v, input bit expect_word);
    for (int b = 15; b >= 0; b--) begin
      drive_bit(b == 15, v[b]);
      if (b == 15 && lat_rec) begin
        t_fs    = $time;
        lat_rec = 0;
      end
    end
    if (expect_word) exp_q.push_back(v);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_bit(1'b0, k[0]);
  endtask

  task automatic pulse_clr();
    @(posedge sys_clk);
    #1 i_clr = 1'b1;
    @(posedge sys_clk);
    #1 i_clr = 1'b0;
  endtask

  task automatic drain(input string name);
    rx_if.i_rdy = 1'b1;
    for (int k = 0; k < 200 && o_level != 0; k++) @(posedge sys_clk);
    #1;
    check({name, "_drain_level"}, 32'(o_level), 32'd0);
    check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every transfer is checked against the scoreboard head.
  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (lat_arm && rx_if.o_vld) begin
        check("first_word_latency", 32'(($time - t_fs) / 10), 32'd17);
        lat_arm = 0;
      end
      if (rx_if.o_vld && hold_prev) check("hold_stable", 32'(rx_if.o_data), 32'(prev_data));
      if (rx_if.o_vld && rx_if.i_rdy) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", rx_if.o_data, $time);
        end else begin
          check("word", 32'(rx_if.o_data), 32'(exp_q.pop_front()));
        end
      end
      hold_prev = rx_if.o_vld && !rx_if.i_rdy;
      prev_data = rx_if.o_data;
    end else begin
      hold_prev = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    i_fs        = 1'b0;
    i_d         = 1'b0;
    i_clr       = 1'b0;
    rx_if.i_rdy = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_vld",   32'(rx_if.o_vld), 32'd0);
    check("rst_data",  32'(rx_if.o_data), 32'd0);
    check("rst_level", 32'(o_level), 32'd0);
    check("rst_ovf",   32'(o_ovf), 32'd0);
    check("rst_ferr",  32'(o_ferr), 32'd0);
    check("rst_drop",  32'(o_drop_cnt), 32'd0);
    rst_n = 1'b1;
    idle(3);

    // back-to-back frames, consumer always ready
    rx_if.i_rdy = 1'b1;
    lat_rec = 1;
    lat_arm = 1;
    send_frame(16'h0001, 1);
    send_frame(16'h0002, 1);
    send_frame(16'h0003, 1);
    idle(20);
    check("b2b_latency_seen", 32'(lat_arm), 32'd0);
    drain("b2b");

    // overflow: ten frames into an eight-deep buffer
    rx_if.i_rdy = 1'b0;
    for (int i = 0; i < 10; i++) send_frame(16'(i), i < 8);
    idle(4);
    check("ovf_level", 32'(o_level), 32'd8);
    check("ovf_flag",  32'(o_ovf), 32'd1);
    check("ovf_drop",  32'(o_drop_cnt), 32'd2);
    check("ovf_ferr",  32'(o_ferr), 32'd0);
    drain("ovf");
    check("ovf_sticky", 32'(o_ovf), 32'd1);
    pulse_clr();
    check("ovf_clr_flag", 32'(o_ovf), 32'd0);
    check("ovf_clr_drop", 32'(o_drop_cnt), 32'd0);

    // frame error: new strobe five bits into a frame
    rx_if.i_rdy = 1'b1;
    begin
      logic [15:0] part;
      part = 16'h5A5A;
      for (int b = 15; b > 10; b--) drive_bit(b == 15, part[b]);
    end
    send_frame(16'hBEEF, 1);
    idle(20);
    check("ferr_flag", 32'(o_ferr), 32'd1);
    drain("ferr");
    pulse_clr();
    check("ferr_clr", 32'(o_ferr), 32'd0);

    // full buffer: push and pop on the same edge
    rx_if.i_rdy = 1'b0;
    for (int i = 0; i < 9; i++) send_frame(16'h0010 + 16'(i), 1);
    @(posedge sys_clk);
    #1 rx_if.i_rdy = 1'b1;
    @(posedge sys_clk);
    #1 rx_if.i_rdy = 1'b0;
    @(negedge sys_clk);
    check("full_pp_level", 32'(o_level), 32'd8);
    check("full_pp_drop",  32'(o_drop_cnt), 32'd0);
    check("full_pp_ovf",   32'(o_ovf), 32'd0);
    idle(2);
    drain("full_pp");

    // reset in the middle of a frame
    begin
      logic [15:0] aa;
      aa = 16'hA5A5;
      for (int b = 15; b > 7; b--) drive_bit(b == 15, aa[b]);
    end
    @(posedge sys_clk);
    #1 rst_n = 1'b0;
    #2;
    check("midrst_vld",   32'(rx_if.o_vld), 32'd0);
    check("midrst_data",  32'(rx_if.o_data), 32'd0);
    check("midrst_level", 32'(o_level), 32'd0);
    check("midrst_ovf",   32'(o_ovf), 32'd0);
    check("midrst_ferr",  32'(o_ferr), 32'd0);
    check("midrst_drop",  32'(o_drop_cnt), 32'd0);
    @(posedge sys_clk);
    #1 rst_n = 1'b1;
    idle(30);
    check("midrst_no_word", 32'(o_level), 32'd0);
    send_frame(16'h1234, 1);
    idle(20);
    drain("midrst");

    // drop counter saturation and clear
    rx_if.i_rdy = 1'b0;
    for (int i = 0; i < 308; i++) send_frame(16'h0100 + 16'(i), i < 8);
    idle(4);
    check("sat_drop",  32'(o_drop_cnt), 32'd255);
    check("sat_ovf",   32'(o_ovf), 32'd1);
    check("sat_level", 32'(o_level), 32'd8);
    @(posedge sys_clk);
    #1 i_clr = 1'b1;
    @(posedge sys_clk);
    #1 i_clr = 1'b0;
    @(negedge sys_clk);
    check("sat_clr_drop",  32'(o_drop_cnt), 32'd0);
    check("sat_clr_ovf",   32'(o_ovf), 32'd0);
    check("sat_clr_level", 32'(o_level), 32'd8);
    drain("sat");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
